// File: rtl/posit_data_encode.sv
// posit_data_encode: 3-stage packer of unpacked posit fields into an N-bit posit word, rounding to nearest even and saturating.
// Define POSIT_ENCODE_STICKY_EN to add a sticky_i input that is OR'd into the rounding sticky bit.
module posit_data_encode #(
  parameter int POSIT_WIDTH    = 8,
  parameter int POSIT_ES       = 0,
  parameter int SCALE_WIDTH    = $clog2(POSIT_WIDTH - 1) + 1 + POSIT_ES,
  parameter int FRACTION_WIDTH = POSIT_WIDTH - 3 - POSIT_ES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      sign_i,
  input  logic                      inf_i,
  input  logic                      zero_i,
  input  logic [SCALE_WIDTH-1:0]    scale_i,
  input  logic [FRACTION_WIDTH-1:0] fraction_i,
`ifdef POSIT_ENCODE_STICKY_EN
  input  logic                      sticky_i,
`endif
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [POSIT_WIDTH-1:0]    posit_word_o
);
  localparam int N  = POSIT_WIDTH;
  localparam int ES = POSIT_ES;
  localparam int SW = SCALE_WIDTH;
  localparam int EF = POSIT_ES + FRACTION_WIDTH;
  localparam int T  = N + EF + 2;
  localparam logic signed [SW:0] MAX_SCALE = (SW + 1)'((N - 2) << ES);
  localparam logic [N-2:0] MAXPOS = '1;
  localparam logic [N-2:0] MINPOS = (N - 1)'(1);
  logic en, sticky_in;
  assign en = ~valid_o | ready_i;
  assign ready_o = en;
`ifdef POSIT_ENCODE_STICKY_EN
  assign sticky_in = sticky_i;
`else
  assign sticky_in = 1'b0;
`endif
  logic v1_q, sign1_q, inf1_q, zero1_q, smax1_q, smin1_q, st1_q;
  logic signed [SW-1:0] k1_q, k1_d;
  logic [EF-1:0] ef1_q, ef1_d;
  logic signed [SW:0] scale_x;
  logic smax1_d, smin1_d;
  always_comb begin
    scale_x = {scale_i[SW-1], scale_i};
    k1_d = $signed(scale_i) >>> ES;
    ef1_d = EF'({scale_i, fraction_i});
    smax1_d = scale_x > MAX_SCALE;
    smin1_d = scale_x < -MAX_SCALE;
  end
  logic v2_q, sign2_q, inf2_q, zero2_q;
  logic [N-2:0] mag2_q, mag2_d;
  logic [SW:0] sh;
  logic [T-1:0] base, fld;
  logic [N-1:0] rnd;
  logic k_neg, guard, sticky;
  // The regime terminator leads the field; shifting right by the run length fills in the run itself.
  always_comb begin
    k_neg = k1_q[SW-1];
    sh = k_neg ? -{k1_q[SW-1], k1_q} : {k1_q[SW-1], k1_q} + (SW + 1)'(1);
    base = {k_neg, ef1_q, {(T - 1 - EF){1'b0}}};
    fld = (base >> sh) | (k_neg ? '0 : ~({T{1'b1}} >> sh));
    guard = fld[T-N];
    sticky = (|fld[T-N-1:0]) | st1_q;
    rnd = {1'b0, fld[T-1 -: N-1]} + N'(guard & (fld[T-N+1] | sticky));
    mag2_d = (smax1_q | rnd[N-1]) ? MAXPOS : (smin1_q | ~|rnd) ? MINPOS : rnd[N-2:0];
  end
  logic [N-1:0] word_d;
  always_comb begin
    word_d = inf2_q ? {1'b1, {(N - 1){1'b0}}} : zero2_q ? '0 : sign2_q ? -{1'b0, mag2_q} : {1'b0, mag2_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      sign1_q <= 1'b0;
      inf1_q <= 1'b0;
      zero1_q <= 1'b0;
      smax1_q <= 1'b0;
      smin1_q <= 1'b0;
      st1_q <= 1'b0;
      k1_q <= '0;
      ef1_q <= '0;
      v2_q <= 1'b0;
      sign2_q <= 1'b0;
      inf2_q <= 1'b0;
      zero2_q <= 1'b0;
      mag2_q <= '0;
      valid_o <= 1'b0;
      posit_word_o <= '0;
    end else if (en) begin
      v1_q <= valid_i;
      sign1_q <= sign_i;
      inf1_q <= inf_i;
      zero1_q <= zero_i;
      smax1_q <= smax1_d;
      smin1_q <= smin1_d;
      st1_q <= sticky_in;
      k1_q <= k1_d;
      ef1_q <= ef1_d;
      v2_q <= v1_q;
      sign2_q <= sign1_q;
      inf2_q <= inf1_q;
      zero2_q <= zero1_q;
      mag2_q <= mag2_d;
      valid_o <= v2_q;
      posit_word_o <= word_d;
    end
  end
endmodule

// File: tb/tb_posit_data_encode.sv
// tb_posit_data_encode: directed, streaming and random checks of posit_data_encode (N=8, ES=0)
// against a model that picks the nearest posit value, ties to the even pattern.
module tb_posit_data_encode;
  logic clk = 1'b0;
  logic rst, valid_i, ready_o, sign_i, inf_i, zero_i, sticky_i, valid_o, ready_i;
  logic [3:0] scale_i;
  logic [4:0] fraction_i;
  logic [7:0] posit_word_o;
  int n_assert = 0, n_fail = 0, got = 0, idx;
  logic [7:0] exp_q[$];
  logic [7:0] next_exp, held, word_s;
  logic acc, rdy_s, vo_s;
  logic ds, dinf, dz;
  int dsc;
  logic [4:0] dfr;
  real pv[128];
  always #5 clk = ~clk;
  posit_data_encode #(.POSIT_WIDTH(8), .POSIT_ES(0), .SCALE_WIDTH(4), .FRACTION_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .sign_i(sign_i), .inf_i(inf_i),
    .zero_i(zero_i), .scale_i(scale_i), .fraction_i(fraction_i),
`ifdef POSIT_ENCODE_STICKY_EN
    .sticky_i(sticky_i),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .posit_word_o(posit_word_o)
  );
  function automatic real pow2(input int s);
    real r = 1.0;
    if (s >= 0) repeat (s) r = r * 2.0;
    else repeat (-s) r = r / 2.0;
    return r;
  endfunction
  task automatic decode(input logic [7:0] w, output logic s, output logic inf, output logic z,
                        output int sc, output logic [4:0] fr);
    logic [7:0] m;
    int i, run;
    s = w[7]; inf = (w == 8'h80); z = (w == 8'h00); sc = 0; fr = '0;
    if (!inf && !z) begin
      m = s ? -w : w;
      run = 0; i = 6;
      while (i >= 0 && m[i] == m[6]) begin run++; i--; end
      sc = m[6] ? run - 1 : -run;
      i = i - 1;
      for (int b = 4; b >= 0; b--) if (i >= 0) begin fr[b] = m[i]; i--; end
    end
  endtask
  function automatic logic [7:0] ref_encode(input logic s, input logic inf, input logic z,
                                            input int sc, input logic [4:0] fr, input logic st);
    real v, mid;
    int m;
    if (inf) return 8'h80;
    if (z) return 8'h00;
    v = pow2(sc) * (1.0 + real'(fr) / 32.0);
    m = 1;
    if (v >= pv[127]) m = 127;
    else if (v > pv[1])
      for (int i = 1; i < 127; i++)
        if (v >= pv[i] && v < pv[i+1]) begin
          mid = (pv[i] + pv[i+1]) / 2.0;
          m = (v < mid || (v == mid && !st && i % 2 == 0)) ? i : i + 1;
        end
    return s ? 8'(-m) : 8'(m);
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic s, input logic inf, input logic z,
                       input int sc, input logic [4:0] fr, input logic st);
    valid_i = v; sign_i = s; inf_i = inf; zero_i = z; scale_i = 4'(sc); fraction_i = fr;
`ifdef POSIT_ENCODE_STICKY_EN
    sticky_i = st;
`else
    sticky_i = 1'b0 & st;
`endif
    next_exp = ref_encode(s, inf, z, sc, fr, sticky_i);
  endtask
  task automatic step();
    #1;
    acc = valid_i && ready_o; rdy_s = ready_o; vo_s = valid_o; word_s = posit_word_o;
    if (valid_o && ready_i) begin
      got++;
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious: observed word 0x%0h, expected no output", posit_word_o);
      end
      if (exp_q.size() > 0) chk("stream", int'(posit_word_o), int'(exp_q.pop_front()));
    end
    if (acc) exp_q.push_back(next_exp);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n = 0;
    valid_i = 1'b0; ready_i = 1'b1;
    while (exp_q.size() > 0 && n < 20) begin step(); n++; end
    chk("drain empty", exp_q.size(), 0);
    repeat (4) step();
  endtask
  task automatic single(input string tag, input logic s, input logic inf, input logic z,
                        input int sc, input logic [4:0] fr, input logic st, input logic [7:0] exp);
    int cyc = 0;
    ready_i = 1'b1;
    drive(1'b1, s, inf, z, sc, fr, st);
    @(posedge clk); #1;
    valid_i = 1'b0;
    while (!valid_o && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, cyc, 2);
    chk(tag, int'(posit_word_o), int'(exp));
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sign_i = 1'b0; inf_i = 1'b0; zero_i = 1'b0;
    scale_i = '0; fraction_i = '0; sticky_i = 1'b0; next_exp = '0; pv[0] = 0.0;
    for (int p = 1; p < 128; p++) begin
      decode(8'(p), ds, dinf, dz, dsc, dfr);
      pv[p] = pow2(dsc) * (1.0 + real'(dfr) / 32.0);
    end
    #2;
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset ready_o", int'(ready_o), 1);
    chk("reset word", int'(posit_word_o), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    single("one", 1'b0, 1'b0, 1'b0, 0, 5'b00000, 1'b0, 8'h40);
    single("minus one", 1'b1, 1'b0, 1'b0, 0, 5'b00000, 1'b0, 8'hC0);
    single("half", 1'b0, 1'b0, 1'b0, -1, 5'b00000, 1'b0, 8'h20);
    single("zero", 1'b0, 1'b0, 1'b1, 3, 5'b10101, 1'b0, 8'h00);
    single("nar", 1'b0, 1'b1, 1'b0, 2, 5'b00110, 1'b0, 8'h80);
    single("nar and zero", 1'b0, 1'b1, 1'b1, 0, 5'b00000, 1'b0, 8'h80);
    single("negative zero", 1'b1, 1'b0, 1'b1, 0, 5'b00000, 1'b0, 8'h00);
    single("sat max", 1'b0, 1'b0, 1'b0, 7, 5'b00000, 1'b0, 8'h7F);
    single("sat min", 1'b0, 1'b0, 1'b0, -8, 5'b00000, 1'b0, 8'h01);
    single("neg sat max", 1'b1, 1'b0, 1'b0, 7, 5'b00000, 1'b0, 8'h81);
    single("tie to even", 1'b0, 1'b0, 1'b0, 5, 5'b10000, 1'b0, 8'h7E);
    single("above tie", 1'b0, 1'b0, 1'b0, 5, 5'b10001, 1'b0, 8'h7F);
    single("exact frac", 1'b0, 1'b0, 1'b0, 0, 5'b11111, 1'b0, 8'h5F);
`ifdef POSIT_ENCODE_STICKY_EN
    single("sticky tie", 1'b0, 1'b0, 1'b0, 5, 5'b10000, 1'b1, 8'h7F);
`endif
    idx = 0; got = 0; held = '0;
    for (int c = 0; c < 40 && (idx < 10 || exp_q.size() > 0); c++) begin
      ready_i = !(c >= 6 && c < 10);
      drive(idx < 10, 1'b0, 1'b0, 1'b0, idx - 4, 5'(idx * 7), 1'b0);
      step();
      if (acc) idx++;
      if (c == 6) held = word_s;
      if (c >= 6 && c < 10) begin
        chk("bp ready_o low", int'(rdy_s), 0);
        chk("bp valid_o held", int'(vo_s), 1);
      end
      if (c >= 7 && c < 10) chk("bp word stable", int'(word_s), int'(held));
    end
    chk("bp delivered", got, 10);
    drain();
    ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, j, 5'(j + 3), 1'b0);
      step();
    end
    chk("pre-reset valid_o", int'(valid_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset valid_o", int'(valid_o), 0);
    chk("async reset ready_o", int'(ready_o), 1);
    chk("async reset word", int'(posit_word_o), 0);
    exp_q.delete();
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("no stale word", int'(valid_o), 0);
    end
    single("post-reset two", 1'b0, 1'b0, 1'b0, 1, 5'b00000, 1'b0, 8'h60);
    ready_i = 1'b1;
    for (int w = 0; w < 256; w++) begin
      decode(8'(w), ds, dinf, dz, dsc, dfr);
      drive(1'b1, ds, dinf, dz, dsc, dfr, 1'b0);
      next_exp = 8'(w);
      step();
    end
    drain();
    for (int j = 0; j < 400; j++) begin
      ready_i = $urandom_range(0, 3) != 0;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)) - 8, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      step();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_data_encode.md
Name: posit_data_encode

Overview:
- Inverse of the posit decode path.
- Takes unpacked posit fields (sign, inf, zero, scale, fraction) from the arithmetic units and packs them into a POSIT_WIDTH-bit posit word.
- Rounds to nearest, ties to even, and saturates to maxpos/minpos.
- 3-stage pipeline with valid/ready handshakes on both sides; sits at the output of the PE datapath before writeback.

Parameters:
- POSIT_WIDTH, 8: total posit word width N (>= 5).
- POSIT_ES, 0: exponent field width.
- SCALE_WIDTH, GET_SCALE_WIDTH(POSIT_WIDTH, POSIT_ES, 0): signed scale width.
- FRACTION_WIDTH, GET_FRACTION_WIDTH(POSIT_WIDTH, POSIT_ES, 0): fraction width. Hidden bit is excluded; MSB is the first bit after the binary point.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- valid_i  in  1  input fields valid.
- ready_o  out  1  block can accept input this cycle.
- sign_i  in  1  sign of the value.
- inf_i  in  1  value is NaR.
- zero_i  in  1  value is zero.
- scale_i  in  SCALE_WIDTH  two's-complement scale: value = 2^scale * 1.fraction.
- fraction_i  in  FRACTION_WIDTH  fraction bits.
- valid_o  out  1  posit_word_o valid.
- ready_i  in  1  downstream accepts this cycle.
- posit_word_o  out  POSIT_WIDTH  encoded posit.

Behaviour:
- Reset: all stage valids clear; valid_o=0, posit_word_o=0, ready_o=1 while rst is high. Reset asserted mid-operation discards all in-flight data.
- Handshake:
  - Input transfer when valid_i && ready_o; output transfer when valid_o && ready_i.
  - Global advance enable en = ~valid_o | ready_i; ready_o = en. Combinational ready path is permitted.
  - When en=0, every stage register holds and posit_word_o/valid_o stay stable.
  - Bubbles propagate: a stage valid loads 0 when its upstream is empty.
- Latency: 3 cycles from input transfer to valid_o with ready_i held high. Throughput is 1 word/cycle. Order is preserved; no drop, no duplication.
- Stage 1, decompose and clamp:
  - k = scale_i >>> ES (arithmetic shift); e = scale_i[ES-1:0].
  - maxscale = (N-2)*2^ES; minscale = -maxscale.
  - scale > maxscale sets flag sat_max; scale < minscale sets flag sat_min.
- Stage 2, assemble and round:
  - Regime for k>=0: k+1 ones then a 0. Regime for k<0: -k zeros then a 1.
  - Concatenate regime, e, fraction into an unbounded field; truncate to N-1 magnitude bits.
  - guard = first dropped bit; sticky = OR of remaining dropped bits.
  - Round up iff guard && (lsb || sticky).
  - A rounding carry into the sign position clamps to maxpos (0 then N-1 ones). A nonzero input never rounds to 0: minimum magnitude is minpos = 1.
  - sat_max gives maxpos; sat_min gives minpos.
- Stage 3, sign and special cases:
  - sign=1 takes the two's complement of the magnitude.
  - Priority: inf_i gives 1 followed by N-1 zeros (0x80 for N=8). Otherwise zero_i gives all zeros. Otherwise the rounded result.
  - Sign is ignored for inf/zero.
- Arithmetic: all shifts use internal width >= N+FRACTION_WIDTH+2 so no rounding information is lost before guard/sticky extraction.

Optional Feature:
- Macro: POSIT_ENCODE_STICKY_EN.
- Defined: adds port sticky_i (in, 1). It is OR'd into the stage-2 sticky bit, carrying information lost upstream (e.g. accumulator truncation), and is pipelined alongside the other fields.
- Undefined: no port; sticky comes only from bits dropped inside the block.

Test Plan:
- N=8, ES=0. 1.0 (sign0, scale0, frac0) -> 0x40, valid_o exactly 3 cycles after acceptance. -1.0 -> 0xC0. Scale -1, frac0 (0.5) -> 0x20.
- Specials: zero_i=1 -> 0x00. inf_i=1 -> 0x80. inf_i=zero_i=1 -> 0x80. sign1 with zero_i=1 -> 0x00.
- Saturation: scale 7 -> 0x7F. Scale -8 -> 0x01. Sign1, scale 7 -> 0x81.
- Rounding at scale 5 (no fraction room): frac 5'b10000 is an exact tie with lsb 0 -> 0x7E. Frac 5'b10001 -> 0x7F. Scale 0, frac 5'b11111 -> 0x5F (exact). With the macro defined: scale 5, frac 5'b10000, sticky_i=1 -> 0x7F.
- Backpressure: stream 10 sequential encodings; ready_i low for 4 cycles midway. Check ready_o falls once all 3 stages are full, posit_word_o stays stable, and the output sequence equals the input order with no loss or duplication.
- Reset: assert rst with 3 words in flight -> valid_o=0 immediately (asynchronous). After release the first new word emerges 3 cycles post acceptance; no stale words appear.
- Exhaustive: for all 256 8-bit posits, decode, then re-encode through this block; the output must equal the original word.
